// File: rtl/voice_scheduler.sv
// voice_scheduler: frame-paced wavetable read scheduler and signed voice mixer
// Ports: i_clk_50 clock, i_ar sync active-high reset, i_frame_tick frame pulse;
//        i_voice_on / i_voice_step / i_wave_select voice controls;
//        o_mem_addr, o_mem_rd, i_mem_done, i_mem_dout sample-memory read port;
//        o_mix_out / o_mix_valid mixed big-endian sample; o_overrun / o_mem_timeout sticky errors.
// Option: define MIX_SAT_EN to saturate the mix to 16 bits instead of wrapping it.
module voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 13,
    parameter int TIMEOUT    = 64
) (
    input  logic                    i_clk_50,
    input  logic                    i_ar,
    input  logic                    i_frame_tick,
    input  logic [NUM_VOICES-1:0]   i_voice_on,
    input  logic [8*NUM_VOICES-1:0] i_voice_step,
    input  logic [1:0]              i_wave_select,
    output logic [PHASE_W+1:0]      o_mem_addr,
    output logic                    o_mem_rd,
    input  logic                    i_mem_done,
    input  logic [15:0]             i_mem_dout,
    output logic [15:0]             o_mix_out,
    output logic                    o_mix_valid,
    output logic                    o_overrun,
    output logic                    o_mem_timeout
);
    localparam int VW = $clog2(NUM_VOICES);
    localparam int AW = 16 + VW;
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, SELECT, ISSUE, WAIT, OUTPUT} state_t;
    state_t                r_state;
    state_t                w_next;
    logic [NUM_VOICES-1:0] r_snap_on;
    logic [1:0]            r_snap_ws;
    logic [VW-1:0]         r_v;
    logic [AW-1:0]         r_acc;
    logic [PHASE_W-1:0]    r_phase [NUM_VOICES];
    logic [TW-1:0]         r_tcnt;
    logic [15:0]           r_mix_out;
    logic                  r_mix_valid;
    logic                  r_overrun;
    logic                  r_mem_timeout;
    logic [15:0]           w_sample;
    logic [15:0]           w_mix;
    logic [7:0]            w_step;
    logic                  w_last;
    logic                  w_active;
    logic                  w_fin;
    assign w_sample = {i_mem_dout[7:0], i_mem_dout[15:8]};
    assign w_step   = i_voice_step[{r_v, 3'b000} +: 8];
    assign w_last   = r_v == VW'(NUM_VOICES - 1);
    assign w_active = r_snap_on[r_v];
    // a read finishes on data or once its TIMEOUT-th WAIT cycle passes empty
    assign w_fin    = (r_state == WAIT) && (i_mem_done || r_tcnt == TW'(TIMEOUT - 1));
`ifdef MIX_SAT_EN
    // bits above 15 that disagree with the sign bit mean the sum left 16-bit range
    assign w_mix = (r_acc[AW-1:15] == {(AW-15){r_acc[AW-1]}}) ? r_acc[15:0] :
                   (r_acc[AW-1] ? 16'h8000 : 16'h7FFF);
`else
    assign w_mix = r_acc[15:0];
`endif
    assign o_mix_out     = r_mix_out;
    assign o_mix_valid   = r_mix_valid;
    assign o_overrun     = r_overrun;
    assign o_mem_timeout = r_mem_timeout;
    always_ff @(posedge i_clk_50) r_state <= i_ar ? IDLE : w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_frame_tick ? SELECT : IDLE;
            SELECT:  w_next = w_active ? ISSUE : (w_last ? OUTPUT : SELECT);
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = w_fin ? (w_last ? OUTPUT : SELECT) : WAIT;
            OUTPUT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        o_mem_rd   = r_state == ISSUE;
        o_mem_addr = o_mem_rd ? {r_snap_ws, r_phase[r_v]} : '0;
    end
    always_ff @(posedge i_clk_50) begin
        if (i_ar) begin
            r_snap_on     <= '0;
            r_snap_ws     <= '0;
            r_v           <= '0;
            r_acc         <= '0;
            r_tcnt        <= '0;
            r_mix_out     <= '0;
            r_mix_valid   <= 1'b0;
            r_overrun     <= 1'b0;
            r_mem_timeout <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) r_phase[i] <= '0;
        end else begin
            r_mix_valid <= 1'b0;
            if (i_frame_tick && r_state != IDLE) r_overrun <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (i_frame_tick) begin
                        r_snap_on <= i_voice_on;
                        r_snap_ws <= i_wave_select;
                        r_v       <= '0;
                        r_acc     <= '0;
                    end
                end
                SELECT: begin
                    if (!w_active) begin
                        r_phase[r_v] <= '0;
                        if (!w_last) r_v <= r_v + 1'b1;
                    end
                end
                ISSUE: r_tcnt <= '0;
                WAIT: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (w_fin) begin
                        if (i_mem_done) r_acc <= r_acc + {{VW{w_sample[15]}}, w_sample};
                        else r_mem_timeout <= 1'b1;
                        r_phase[r_v] <= r_phase[r_v] + PHASE_W'(w_step);
                        if (!w_last) r_v <= r_v + 1'b1;
                    end
                end
                OUTPUT: begin
                    r_mix_out   <= w_mix;
                    r_mix_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_voice_scheduler.sv
// tb_voice_scheduler: scoreboard bench for voice_scheduler with a latency-programmable memory model
module tb_voice_scheduler;
    logic        clk = 1'b0;
    logic        ar = 1'b1;
    logic        tick = 1'b0;
    logic [3:0]  von = '0;
    logic [31:0] vstep = '0;
    logic [1:0]  ws = '0;
    logic [14:0] mem_addr;
    logic        mem_rd;
    logic        mem_done = 1'b0;
    logic [15:0] mem_dout = '0;
    logic [15:0] mix_out;
    logic        mix_valid;
    logic        overrun;
    logic        mem_timeout;
`ifdef MIX_SAT_EN
    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;
`else
    localparam logic [15:0] SAT_POS = 16'h0000;
    localparam logic [15:0] SAT_NEG = 16'h0000;
`endif
    typedef struct {
        logic [15:0] mix;
        int          cyc;
    } exp_t;
    exp_t        exp_q[$];
    logic [14:0] addr_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          tick_cyc = 0;
    logic [15:0] mem_data = 16'h3412;
    int          mem_d = 1;
    bit          mem_dead = 1'b0;
    int          mem_cnt = 0;
    bit          prev_rd = 1'b0;

    voice_scheduler dut (
        .i_clk_50(clk), .i_ar(ar), .i_frame_tick(tick), .i_voice_on(von),
        .i_voice_step(vstep), .i_wave_select(ws), .o_mem_addr(mem_addr),
        .o_mem_rd(mem_rd), .i_mem_done(mem_done), .i_mem_dout(mem_dout),
        .o_mix_out(mix_out), .o_mix_valid(mix_valid), .o_overrun(overrun),
        .o_mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string msg);
        checks++;
        failures++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // memory responder and read-address monitor
    always @(posedge clk) begin
        #1;
        mem_done = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                mem_done = 1'b1;
                mem_dout = mem_data;
            end
        end
        if (mem_rd) begin
            if (prev_rd) fail("rd_back_to_back", "got mem_rd high two cycles running, expected single pulses");
            if (addr_q.size() == 0) fail("unexpected_rd", $sformatf("got read at %0h, expected no read", mem_addr));
            else chk("rd_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
            if (!mem_dead) mem_cnt = mem_d;
        end
        prev_rd = mem_rd;
    end

    // mix monitor
    always @(posedge clk) begin : mix_mon
        exp_t e;
        #1;
        if (mix_valid) begin
            if (exp_q.size() == 0) begin
                fail("unexpected_mix", $sformatf("got mix_valid with mix_out=%0h, expected none", mix_out));
            end else begin
                e = exp_q.pop_front();
                chk("mix_out", 64'(mix_out), 64'(e.mix));
                chk("mix_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic step_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [15:0] mix, input int lat);
        exp_t e;
        e.mix = mix;
        e.cyc = cyc + lat;
        exp_q.push_back(e);
        tick = 1'b1;
        tick_cyc = cyc;
        step_clk(1);
        tick = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || addr_q.size() != 0) && n < 300) begin
            step_clk(1);
            n++;
        end
        if (n >= 300) begin
            fail("drain_timeout", $sformatf("got %0d mixes / %0d reads pending, expected 0", exp_q.size(), addr_q.size()));
            exp_q.delete();
            addr_q.delete();
        end
        step_clk(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        step_clk(1);
        chk("reset_outs0", {mem_rd, mem_addr, mix_out, mix_valid, overrun, mem_timeout}, 0);
        step_clk(1);
        chk("reset_outs1", {mem_rd, mem_addr, mix_out, mix_valid, overrun, mem_timeout}, 0);
        ar = 1'b0;
        step_clk(1);
        frame(16'h0000, 6);
        drain();
        von = 4'b0001;
        vstep = 32'd74;
        ws = 2'b01;
        mem_data = 16'h3412;
        mem_d = 1;
        addr_q.push_back(15'h2000);
        frame(16'h1234, 8);
        drain();
        addr_q.push_back(15'h204A);
        frame(16'h1234, 8);
        drain();
        addr_q.push_back(15'h2094);
        frame(16'h1234, 8);
        drain();
        von = 4'b1111;
        vstep = '0;
        mem_data = 16'h0040;
        addr_q.push_back(15'h20DE);
        repeat (3) addr_q.push_back(15'h2000);
        frame(SAT_POS, 14);
        drain();
        mem_data = 16'h0080;
        addr_q.push_back(15'h20DE);
        repeat (3) addr_q.push_back(15'h2000);
        frame(SAT_NEG, 14);
        drain();
        von = 4'b0010;
        vstep = 32'h0000_FF00;
        mem_data = 16'h3412;
        for (int k = 0; k < 32; k++) begin
            addr_q.push_back(15'h2000 | 15'(k * 255));
            frame(16'h1234, 8);
            drain();
        end
        vstep = 32'h0000_1E00;
        addr_q.push_back(15'h3FE0);
        frame(16'h1234, 8);
        drain();
        vstep = 32'h0000_9400;
        addr_q.push_back(15'h3FFE);
        frame(16'h1234, 8);
        drain();
        addr_q.push_back(15'h2092);
        frame(16'h1234, 8);
        drain();
        von = 4'b0000;
        frame(16'h0000, 6);
        drain();
        vstep = '0;
        von = 4'b0010;
        addr_q.push_back(15'h2000);
        frame(16'h1234, 8);
        drain();
        chk("overrun_clear", 64'(overrun), 0);
        von = 4'b1111;
        mem_d = 20;
        repeat (4) addr_q.push_back(15'h2000);
        frame(16'h48D0, 90);
        step_clk(29);
        tick = 1'b1;
        step_clk(1);
        tick = 1'b0;
        chk("overrun_set", 64'(overrun), 1);
        drain();
        step_clk(20);
        chk("overrun_sticky", 64'(overrun), 1);
        chk("timeout_clear", 64'(mem_timeout), 0);
        von = 4'b0001;
        vstep = 32'd5;
        mem_d = 1;
        mem_dead = 1'b1;
        addr_q.push_back(15'h2000);
        frame(16'h0000, 71);
        drain();
        chk("timeout_set", 64'(mem_timeout), 1);
        mem_dead = 1'b0;
        addr_q.push_back(15'h2005);
        frame(16'h1234, 8);
        drain();
        vstep = '0;
        mem_d = 20;
        addr_q.push_back(15'h200A);
        tick = 1'b1;
        step_clk(1);
        tick = 1'b0;
        step_clk(6);
        ar = 1'b1;
        step_clk(1);
        chk("midread_reset_outs", {mem_rd, mem_addr, mix_out, mix_valid, overrun, mem_timeout}, 0);
        ar = 1'b0;
        step_clk(30);
        chk("late_done_mix", 64'(mix_out), 0);
        chk("late_done_pending", 64'(addr_q.size()), 0);
        mem_d = 1;
        addr_q.push_back(15'h2000);
        frame(16'h1234, 8);
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Time-multiplexes the single wavetable sample-memory read port among `NUM_VOICES` polyphonic voices, once per audio frame. On each frame tick it walks the voices in index order and issues one read per active voice at `{wave_select, phase}`. It then byte-swaps each returned little-endian sample to big-endian, accumulates a signed mix, and advances each voice's phase by its step. It sits between the key/voice-allocation logic and `dpram_ctrl`, and its `mix_out` feeds the codec serializer.

## Interface
- `NUM_VOICES`, 4: number of voices, 2..8.
- `PHASE_W`, 13: per-voice phase accumulator width (sample position).
- `TIMEOUT`, 64: maximum WAIT cycles before a read is abandoned.
- `clk_50`  in  1  system clock; all logic on rising edge.
- `ar`  in  1  reset, synchronous, active-high.
- `frame_tick`  in  1  one-cycle pulse per LRCK frame, already synchronized to `clk_50`.
- `voice_on`  in  NUM_VOICES  per-voice key-on.
- `voice_step`  in  8*NUM_VOICES  per-voice phase increment; voice i at `[8i+7:8i]`.
- `wave_select`  in  2  waveform bank; upper address bits, shared by all voices.
- `mem_addr`  out  2+PHASE_W  read address `{wave_select, phase[i]}`.
- `mem_rd`  out  1  one-cycle read strobe.
- `mem_done`  in  1  read data valid on `mem_dout`.
- `mem_dout`  in  16  sample, little-endian byte order.
- `mix_out`  out  16  signed big-endian mixed sample.
- `mix_valid`  out  1  one-cycle pulse when `mix_out` updates.
- `overrun`  out  1  sticky: `frame_tick` arrived while not IDLE.
- `mem_timeout`  out  1  sticky: a read exceeded `TIMEOUT`.

## Operation
- **States:** IDLE, SELECT, ISSUE, WAIT, OUTPUT.
- **IDLE**
  - On `frame_tick`: latch `voice_on` and `wave_select` into a frame snapshot, set index v=0, clear the accumulator, go to SELECT.
- **SELECT (1 cycle per voice)**
  - Snapshot bit v = 1: go to ISSUE.
  - Snapshot bit v = 0: phase[v] := 0; if v = NUM_VOICES-1 go to OUTPUT, else v++ and stay in SELECT.
- **ISSUE (1 cycle)**
  - `mem_rd` = 1, `mem_addr` = {snapshot `wave_select`, phase[v]}; go to WAIT.
- **WAIT**
  - `mem_done` is sampled starting the cycle after ISSUE. A `mem_done` coincident with `mem_rd` is ignored.
  - On `mem_done`:
    - sample s = {mem_dout[7:0], mem_dout[15:8]}, treated as signed;
    - acc += sign-extended s;
    - phase[v] := (phase[v] + voice_step[v]) mod 2^PHASE_W, zero-extending the step;
    - then advance v or go to OUTPUT, as in SELECT.
  - After `TIMEOUT` WAIT cycles without `mem_done`: contribute 0, still advance the phase, set `mem_timeout`, continue.
- **Accumulator width:** 16 + ceil(log2 NUM_VOICES) bits, signed. No overflow is possible inside it.
- **OUTPUT (1 cycle)**
  - Reduce acc to 16 bits (see Configuration), register into `mix_out`, pulse `mix_valid`, return to IDLE.
- **Mid-frame changes:** `voice_on` and `wave_select` changes during a frame take effect at the next tick. `voice_step` is read live at the phase update.
- **Tick outside IDLE:** ignored; `overrun` is set.
- **Phase wrap:** modular; no clamping.
- **Reset (`ar` high, any state incl. mid-read):**
  - state IDLE, all phases 0, acc 0;
  - `mem_rd` 0, `mem_addr` 0, `mix_out` 0, `mix_valid` 0, `overrun` 0, `mem_timeout` 0;
  - a `mem_done` arriving after reset is ignored.

## Timing
- Cycle k is counted from the edge that samples `frame_tick` high.
- **Cost per voice:**
  - inactive voice: 1 cycle;
  - active voice: 2 + d cycles, where d ≥ 1 is the cycle count from `mem_rd` to `mem_done` (capped at `TIMEOUT`).
- **`mix_valid` arrival:** cycle 1 + Σ(voice cost) + 1.
  - NUM_VOICES=4, all inactive: cycle 6.
  - NUM_VOICES=4, one active voice, d=1: cycle 8.
- At most one `mem_rd` is outstanding; `mem_rd` is never high on consecutive cycles.
- `mix_out` holds between pulses. Worst-case frame must be shorter than the tick period, or `overrun` results.

## Configuration
- **`MIX_SAT_EN` defined:** acc is saturated to the signed 16-bit range.
  - acc > 32767 gives 16'h7FFF.
  - acc < -32768 gives 16'h8000.
- **`MIX_SAT_EN` not defined:** `mix_out` = acc[15:0] (two's-complement wrap). This mode uses less logic.

## Test plan
- **Reset, all voices off:**
  - `ar`=1 for 2 cycles, then one tick with `voice_on`=0 → `mix_valid` at cycle 6 with `mix_out`=0.
  - No `mem_rd` pulse occurs.
  - All outputs are 0 during reset.
- **Single voice, step 74:**
  - Voice 0 on, `voice_step`=74, `wave_select`=2'b01, memory returns 16'h3412 with d=1.
  - Three ticks → `mem_addr` = 15'h2000, 15'h204A, 15'h2094; `mix_out`=16'h1234 each frame; `mix_valid` at cycle 8.
- **Saturation and wrap:**
  - 4 voices on, every sample 16'h0040 (= +16384 after swap) → sum 65536.
  - `MIX_SAT_EN` defined: `mix_out`=16'h7FFF.
  - `MIX_SAT_EN` not defined: `mix_out`=16'h0000.
- **Phase wrap and release:**
  - Phase 8190 + step 148 → next address low bits = 146.
  - Voice then released → its phase is 0 after the next frame, and no read is issued for it.
- **Overrun:**
  - Memory d=20, 4 voices on, second tick 30 cycles after the first → `overrun`=1.
  - First frame completes normally; the second tick is ignored.
- **Timeout and reset mid-read:**
  - `mem_done` never asserts → `mem_timeout`=1 after 64 WAIT cycles; that voice contributes 0.
  - `ar` pulsed during WAIT → IDLE; a late `mem_done` does not change `mix_out`.
